// File: rtl/dsp_fetch_if.sv
// ============================================================================
// dsp_fetch_if : instruction-memory and decode-side signals of the fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface dsp_fetch_if #(
  parameter int PC_WIDTH   = 16,
  parameter int INST_WIDTH = 32
) ();

  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic [INST_WIDTH-1:0] inst_out;
  logic [PC_WIDTH-1:0]   inst_pc;
  logic                  inst_valid;
  logic                  inst_ready;

  // Fetch unit drives requests and the decode-side word.
  modport master (
    output imem_req, imem_addr, inst_out, inst_pc, inst_valid,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_out, inst_pc, inst_valid,
    output imem_rdata, inst_ready
  );

endinterface

`default_nettype wire

// File: rtl/dsp_fetch.sv
// ============================================================================
// dsp_fetch : PC, fixed-latency fetch, 2-entry FIFO to decode, redirect flush.
// Optional JMP predecode under `DSP_FETCH_JMP_PREDECODE_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module dsp_fetch #(
  parameter int                  PC_WIDTH   = 16,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start_i,
  input  wire logic                halt_req_i,
  input  wire logic                redirect_valid_i,
  input  wire logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                     halted_o,
  dsp_fetch_if.master              fetch_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                  kill_q, kill_d;
  logic [INST_WIDTH-1:0] fifo_data_q [2];
  logic [PC_WIDTH-1:0]   fifo_pc_q   [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic w_redirect;
  logic w_pop;
  logic w_push;
  logic w_issue;
  logic w_jmp;

  assign w_redirect = (state_q == ST_RUN) && redirect_valid_i;
  assign w_pop      = (count_q != 2'd0) && fetch_bus.inst_ready;
  assign w_push     = inflight_q && !kill_q && !w_redirect;
  // Credit only occupancy already committed; a same-cycle pop frees nothing.
  assign w_issue    = (state_q == ST_RUN) && !redirect_valid_i &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);

`ifdef DSP_FETCH_JMP_PREDECODE_EN
  assign w_jmp = w_push && (fetch_bus.imem_rdata[INST_WIDTH-1 -: 6] == 6'b100000);
`else
  assign w_jmp = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = w_issue;
    inflight_pc_d = w_issue ? pc_q : inflight_pc_q;
    kill_d        = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    case (state_q)
      ST_IDLE:   if (start_i)    state_d = ST_RUN;
      ST_RUN:    if (halt_req_i) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    if (w_redirect) begin
      pc_d     = redirect_pc_i;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (w_issue) pc_d = pc_q + 1'b1;
      if (w_jmp) begin
        pc_d   = PC_WIDTH'(fetch_bus.imem_rdata[15:0]);
        kill_d = w_issue;
      end
      if (w_pop)  rd_ptr_d = ~rd_ptr_q;
      if (w_push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      kill_q         <= 1'b0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_pc_q[0]   <= '0;
      fifo_pc_q[1]   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      if (w_push) begin
        fifo_data_q[wr_ptr_q] <= fetch_bus.imem_rdata;
        fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      end
    end
  end

  assign fetch_bus.imem_req   = w_issue;
  assign fetch_bus.imem_addr  = pc_q;
  assign fetch_bus.inst_valid = (count_q != 2'd0);
  assign fetch_bus.inst_out   = fifo_data_q[rd_ptr_q];
  assign fetch_bus.inst_pc    = fifo_pc_q[rd_ptr_q];
  assign halted_o             = (state_q == ST_HALTED);

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (count_q == 2'd2)));

endmodule

`default_nettype wire
